// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host-side UART link: 16-bit command sender and 8-bit response receiver
module remote_comm #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        frm_err
);

  localparam int            CW        = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state, tx_nxt;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shift;
  logic [7:0]    cmd_lo;
  logic          accept;
  logic          tx_frame_end;

  rx_state_t     rx_state, rx_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shift;
  logic          rx_wait;
  logic          rx_fall, rx_tick, rx_good_stop, rx_bad_stop;

  // ---------------- transmit side ----------------

  assign accept       = snd_cmd && (tx_state == TX_IDLE);
  assign tx_frame_end = (tx_baud == '0) && (tx_bits == 4'd9);
  assign busy         = (tx_state != TX_IDLE);
  // Shift register idles all-ones, so the line is high whenever nothing is framed.
  assign TX           = tx_shift[0];

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_nxt;
  end

  // TX next state: high byte frame, then low byte frame back-to-back, then idle
  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (accept)       tx_nxt = TX_HIGH;
      TX_HIGH: if (tx_frame_end) tx_nxt = TX_LOW;
      TX_LOW:  if (tx_frame_end) tx_nxt = TX_IDLE;
      default:                   tx_nxt = TX_IDLE;
    endcase
  end

  // TX datapath: baud countdown, bit shifting, low-byte reload and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bits  <= '0;
      cmd_lo   <= '0;
      cmd_snt  <= 1'b0;
    end else if (accept) begin
      cmd_lo   <= cmd[7:0];
      tx_shift <= {1'b1, cmd[15:8], 1'b0};
      tx_baud  <= BAUD_LAST;
      tx_bits  <= '0;
      cmd_snt  <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_baud != '0) begin
        tx_baud <= tx_baud - CW'(1);
      end else begin
        tx_baud <= BAUD_LAST;
        if (tx_bits == 4'd9) begin
          tx_bits <= '0;
          if (tx_state == TX_HIGH) begin
            tx_shift <= {1'b1, cmd_lo, 1'b0};
          end else begin
            tx_shift <= '1;
            cmd_snt  <= 1'b1;
          end
        end else begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bits  <= tx_bits + 4'd1;
        end
      end
    end
  end

  // ---------------- receive side ----------------

  assign rx_fall      = rx_prev && !rx_sync;
  assign rx_tick      = (rx_baud == '0);
  assign rx_good_stop = (rx_state == RX_STOP) && !rx_wait && rx_tick && rx_sync;
  assign rx_bad_stop  = (rx_state == RX_STOP) && !rx_wait && rx_tick && !rx_sync;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  // RX next state: a bad stop bit parks in STOP until the line returns high
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
      RX_START: if (rx_tick) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bits == 4'd7)) rx_nxt = RX_STOP;
      RX_STOP:  if (rx_wait ? rx_sync : (rx_tick && rx_sync)) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // RX datapath: half-bit alignment, mid-bit sampling, LSB-first shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_wait  <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      rx_wait <= 1'b0;
      if (rx_fall) rx_baud <= BAUD_HALF;
    end else begin
      if (!rx_wait) begin
        if (rx_tick) rx_baud <= BAUD_LAST;
        else         rx_baud <= rx_baud - CW'(1);
      end
      if (rx_state == RX_START) rx_bits <= '0;
      if ((rx_state == RX_DATA) && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bits  <= rx_bits + 4'd1;
      end
      if (rx_bad_stop) rx_wait <= 1'b1;
    end
  end

  // Response outputs: a good byte's set takes priority over any clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= rx_bad_stop;
      if (rx_good_stop) begin
        resp     <= rx_shift;
        resp_rdy <= 1'b1;
      end else if (clr_resp_rdy || accept) begin
        resp_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm
`timescale 1ns/1ps
module tb_remote_comm;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0;
  logic        snd_cmd = 1'b0;
  logic        busy, cmd_snt, TX;
  logic        RX = 1'b1;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;
  logic        frm_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];
  bit  mon_en = 1'b1;
  int  tx_nbytes = 0;
  int  tx_last_start = 0;
  int  snt_rises = 0;
  int  err_pulses = 0;
  int  err_w = 0;
  int  rdy_cyc = 0;
  int  rx_a = 0;
  logic snt_prev = 1'b0;
  logic rdy_prev = 1'b0;

  typedef struct {
    logic [15:0] c;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    logic       exp_rdy;
    logic [7:0] exp_resp;
    int         exp_err;
  } rx_vec_t;

  tx_vec_t tx_tab[3];
  rx_vec_t rx_tab[5];

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .busy(busy),
    .cmd_snt(cmd_snt), .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy),
    .clr_resp_rdy(clr_resp_rdy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX line decoder: pops the expected byte for every frame it sees
  always begin : tx_mon
    logic [7:0] b;
    logic       sb;
    int         t0;
    @(negedge clk);
    if (mon_en && (rst_n === 1'b1) && (TX === 1'b0)) begin
      t0 = cyc;
      if ((tx_nbytes % 2) == 1) chk("tx frame gap", t0 - tx_last_start, 10 * BD);
      tx_last_start = t0;
      tx_nbytes++;
      repeat (BD / 2) @(negedge clk);
      chk("tx start bit", TX, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = TX;
      end
      repeat (BD) @(negedge clk);
      sb = TX;
      chk("tx stop bit", sb, 1'b1);
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx unexpected byte: got %0h expected none", b);
      end else begin
        chk("tx byte", b, exp_tx.pop_front());
      end
    end
  end

  // Response / status monitors
  always @(negedge clk) begin
    if (cmd_snt && !snt_prev) snt_rises++;
    snt_prev <= cmd_snt;
    if (resp_rdy && !rdy_prev) begin
      rdy_cyc = cyc;
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx unexpected resp_rdy: got %0h expected none", resp);
      end else begin
        chk("rx resp", resp, exp_resp.pop_front());
      end
    end
    rdy_prev <= resp_rdy;
    if (frm_err) begin
      err_w++;
    end else if (err_w > 0) begin
      chk("frm_err width", err_w, 1);
      err_pulses++;
      err_w = 0;
    end
  end

  task automatic clr_pulse();
    @(posedge clk); #1 clr_resp_rdy = 1'b1;
    @(posedge clk); #1 clr_resp_rdy = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic sb);
    logic [9:0] f;
    f = {sb, d, 1'b0};
    @(posedge clk); #1;
    rx_a = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic run_cmd(input logic [15:0] c, input logic [7:0] hi, input logic [7:0] lo,
                         input bit inject);
    int n, t_snt, bcnt, r0;
    exp_tx.push_back(hi);
    exp_tx.push_back(lo);
    r0 = snt_rises;
    @(posedge clk); #1;
    cmd = c;
    snd_cmd = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    cmd = 16'h0;
    chk("busy after accept", busy, 1'b1);
    chk("cmd_snt cleared on accept", cmd_snt, 1'b0);
    bcnt = 0;
    t_snt = -1;
    for (int k = 0; (k < 1000) && (t_snt < 0); k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (cmd_snt) t_snt = cyc;
      if (inject && (bcnt == 100)) begin
        cmd = 16'h1234;
        snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
    end
    snd_cmd = 1'b0;
    chk("busy cycles", bcnt, 20 * BD);
    chk("cmd_snt latency", t_snt - n, 20 * BD + 1);
    chk("tx bytes drained", exp_tx.size(), 0);
    repeat (50) @(negedge clk);
    chk("cmd_snt sticky", cmd_snt, 1'b1);
    chk("idle after cmd", busy, 1'b0);
    chk("cmd_snt rises once", snt_rises - r0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int e0, d;
    tx_tab[0] = '{16'h2A5C, 8'h2A, 8'h5C};
    tx_tab[1] = '{16'hFF00, 8'hFF, 8'h00};
    tx_tab[2] = '{16'h8001, 8'h80, 8'h01};
    rx_tab[0] = '{8'h33, 1'b0, 1'b1, 1'b0, 8'hA5, 1};
    rx_tab[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0};
    rx_tab[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0};
    rx_tab[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0};
    rx_tab[4] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h81, 1};

    repeat (4) @(negedge clk);
    chk("reset TX", TX, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset cmd_snt", cmd_snt, 1'b0);
    chk("reset resp", resp, 8'h00);
    chk("reset resp_rdy", resp_rdy, 1'b0);
    chk("reset frm_err", frm_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) run_cmd(tx_tab[i].c, tx_tab[i].hi, tx_tab[i].lo, 1'b0);

    // robot answers "in progress" while the low byte is still on the wire
    fork
      run_cmd(16'h7E81, 8'h7E, 8'h81, 1'b0);
      begin
        repeat (170) @(posedge clk);
        exp_resp.push_back(8'h5A);
        rx_send(8'h5A, 1'b1);
      end
    join
    repeat (4) @(negedge clk);
    chk("loop resp_rdy 5A", resp_rdy, 1'b1);
    chk("loop resp 5A", resp, 8'h5A);
    clr_pulse();
    @(negedge clk);
    chk("clr_resp_rdy clears", resp_rdy, 1'b0);
    exp_resp.push_back(8'hA5);
    rx_send(8'hA5, 1'b1);
    repeat (BD) @(negedge clk);
    chk("loop resp_rdy A5", resp_rdy, 1'b1);
    chk("loop resp A5", resp, 8'hA5);

    // short low glitch must be rejected as a false start
    clr_pulse();
    e0 = err_pulses;
    @(posedge clk); #1 RX = 1'b0;
    repeat (5) @(posedge clk);
    #1 RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    chk("glitch no resp_rdy", resp_rdy, 1'b0);
    chk("glitch no frm_err", err_pulses - e0, 0);
    chk("glitch resp kept", resp, 8'hA5);

    for (int i = 0; i < 5; i++) begin
      if (rx_tab[i].clr) clr_pulse();
      e0 = err_pulses;
      if (rx_tab[i].stop && rx_tab[i].clr) exp_resp.push_back(rx_tab[i].data);
      rx_send(rx_tab[i].data, rx_tab[i].stop);
      repeat (2 * BD) @(negedge clk);
      chk($sformatf("rx[%0d] resp_rdy", i), resp_rdy, rx_tab[i].exp_rdy);
      chk($sformatf("rx[%0d] resp", i), resp, rx_tab[i].exp_resp);
      chk($sformatf("rx[%0d] frm_err pulses", i), err_pulses - e0, rx_tab[i].exp_err);
    end

    // locate the stop-bit sample point, then clear in exactly that cycle
    clr_pulse();
    exp_resp.push_back(8'h3C);
    rx_send(8'h3C, 1'b1);
    repeat (2 * BD) @(negedge clk);
    d = rdy_cyc - rx_a;
    chk("rx stop sample window", (d >= 9 * BD + BD / 2) && (d <= 10 * BD + 2), 1'b1);
    clr_pulse();
    @(negedge clk);
    exp_resp.push_back(8'hC5);
    fork
      rx_send(8'hC5, 1'b1);
      begin
        @(posedge clk);
        repeat (d - 1) @(posedge clk);
        #1 clr_resp_rdy = 1'b1;
        @(posedge clk);
        #1 clr_resp_rdy = 1'b0;
      end
    join
    @(negedge clk);
    chk("set beats clr", resp_rdy, 1'b1);
    chk("set beats clr resp", resp, 8'hC5);

    // snd_cmd while busy is ignored
    run_cmd(16'hBEEF, 8'hBE, 8'hEF, 1'b1);

    // reset during the low-byte frame
    mon_en = 1'b0;
    @(posedge clk); #1;
    cmd = 16'hA55A;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    repeat (200) @(negedge clk);
    chk("busy before reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset TX", TX, 1'b1);
    chk("async reset busy", busy, 1'b0);
    chk("async reset resp", resp, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("post reset TX idle", TX, 1'b1);
    mon_en = 1'b1;
    run_cmd(16'h0001, 8'h00, 8'h01, 1'b0);

    repeat (10) @(negedge clk);
    chk("tx scoreboard empty", exp_tx.size(), 0);
    chk("rx scoreboard empty", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
